// File: rtl/veda_lsu_pkg.sv
// VEDA load/store unit: shared types and constants.
// Included by every LSU file through import veda_lsu_pkg::*.
package veda_lsu_pkg;

  localparam int DATA_W_D = 32;
  localparam int DEPTH_D  = 256;
  localparam int OFF_W_D  = 16;
  localparam int TAG_W_D  = 5;
  localparam int STAT_W   = 16;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/veda_lsu_if.sv
// VEDA load/store unit: request, response and memory pin bundle.
// master = execute/writeback/memory side, slave = the LSU.
interface veda_lsu_if
  import veda_lsu_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int OFF_W  = OFF_W_D,
  parameter int TAG_W  = TAG_W_D
);

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [DATA_W-1:0] req_base;
  logic [OFF_W-1:0]  req_offset;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_err;

  logic [DATA_W-1:0] mem_addr;
  logic              mem_mode;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_store, req_base,
    output req_offset, req_wdata, req_tag,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data,
    input  resp_tag, resp_err,
    input  mem_addr, mem_mode,
    input  mem_write_en, mem_write_data
  );

  modport slave (
    input  req_valid, req_store, req_base,
    input  req_offset, req_wdata, req_tag,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data,
    output resp_tag, resp_err,
    output mem_addr, mem_mode,
    output mem_write_en, mem_write_data
  );

endinterface

// File: rtl/veda_lsu_agen.sv
// VEDA load/store unit: effective address generation.
// ea = base + sign-extended offset (wraps), fault when ea >= DEPTH.
module veda_lsu_agen #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int OFF_W  = 16
) (
  input  logic [DATA_W-1:0] base,
  input  logic [OFF_W-1:0]  offset,
  output logic [DATA_W-1:0] ea,
  output logic              fault
);

  logic [DATA_W-1:0] off_sx;

  assign off_sx = {{(DATA_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign ea     = base + off_sx;
  assign fault  = (ea >= DATA_W'(DEPTH));

endmodule

// File: rtl/veda_lsu.sv
// VEDA load/store unit: IDLE -> ACCESS -> RESP sequencer.
// Optional counters behind VEDA_LSU_STATS_EN.
module veda_lsu
  import veda_lsu_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int OFF_W  = OFF_W_D,
  parameter int TAG_W  = TAG_W_D
) (
  input  logic      clk,
  input  logic      rst,
  veda_lsu_if.slave bus
`ifdef VEDA_LSU_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_faults
`endif
);

  lsu_state_e        state;
  logic              st_q;
  logic              flt_q;
  logic [TAG_W-1:0]  tag_q;

  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [TAG_W-1:0]  resp_tag_q;
  logic              resp_err_q;

  logic [DATA_W-1:0] addr_q;
  logic              mode_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] ea;
  logic              fault;

  veda_lsu_agen #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .OFF_W  (OFF_W)
  ) u_agen (
    .base   (bus.req_base),
    .offset (bus.req_offset),
    .ea     (ea),
    .fault  (fault)
  );

  // Sequencer; all outputs registered so ACCESS drives pins cleanly
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      st_q         <= 1'b0;
      flt_q        <= 1'b0;
      tag_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      resp_err_q   <= 1'b0;
      addr_q       <= '0;
      mode_q       <= MEM_READ;
      we_q         <= 1'b0;
      wdata_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state       <= ACCESS;
            req_ready_q <= 1'b0;
            st_q        <= bus.req_store;
            flt_q       <= fault;
            tag_q       <= bus.req_tag;
            addr_q      <= ea;
            if (bus.req_store && !fault) begin
              mode_q  <= MEM_WRITE;
              we_q    <= 1'b1;
              wdata_q <= bus.req_wdata;
            end
          end
        end
        ACCESS: begin
          state        <= RESP;
          mode_q       <= MEM_READ;
          we_q         <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_tag_q   <= tag_q;
          resp_err_q   <= flt_q;
          resp_data_q  <= (flt_q || st_q) ? '0 : bus.mem_rdata;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_tag       = resp_tag_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wdata_q;
  // Reset kills the strobe in the same cycle so an
  // abandoned store never lands at the reset edge.
  assign bus.mem_write_en   = we_q & rst;
  assign bus.mem_mode       = mode_q | ~rst;

`ifdef VEDA_LSU_STATS_EN
  // Saturating per-type counters, bumped as ACCESS retires
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_faults <= '0;
    end else if (state == ACCESS) begin
      if (flt_q)
        stat_faults <= sat_inc(stat_faults);
      else if (st_q)
        stat_stores <= sat_inc(stat_stores);
      else
        stat_loads  <= sat_inc(stat_loads);
    end
  end
`endif

endmodule
